cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-service controller between the CPU memory stage (I-cache or D-cache, one instance each) and the shared multi-cycle main memory. On a cache miss it fetches the 16-byte block containing the missing address as eight pipelined word reads and streams each returned word into the cache data array. It writes the tag array on the last word and holds the CPU stalled through `fsm_busy` until the block is resident.

## Interface

Parameters:
- `WORDS`, default 8: words per cache block. Power of two. Sets the block size to 2*WORDS bytes.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high. Forces IDLE and clears all counters and registered outputs.
- `miss_detected`  in  1  cache reports a miss this cycle. Sampled only in IDLE.
- `miss_address`  in  16  byte address of the missing access. Captured with `miss_detected`.
- `memory_data_valid`  in  1  main memory returns a read word this cycle.
- `memory_data`  in  16  word returned by main memory. Qualified by `memory_data_valid`.
- `fsm_busy`  out  1  fill in progress. The CPU stalls while high.
- `mem_en`  out  1  read request to main memory this cycle.
- `memory_address`  out  16  word-aligned byte address of the current request.
- `write_data_array`  out  1  write `fill_data` into the data array at `data_word_index`.
- `data_word_index`  out  log2(WORDS)  word offset within the block being filled.
- `fill_data`  out  16  word to write. Equals `memory_data`.
- `write_tag_array`  out  1  write the tag/valid for the block. Asserted on the last word only.
- `fill_done`  out  1  one-cycle pulse in the cycle the last word is written.

## Operation

States: IDLE and FILL, held in one state flop. `fsm_busy` = (state == FILL).

- **IDLE:**
  - `mem_en`, `write_data_array`, `write_tag_array` and `fill_done` are 0.
  - `memory_data_valid` is ignored.
  - When `miss_detected`=1: capture `base = miss_address & ~(2*WORDS-1)` (16'hFFF0 at the default), clear `req_cnt` and `rcv_cnt`, and go to FILL.
- **FILL, request side:**
  - While `req_cnt < WORDS`: `mem_en`=1, `memory_address = base + 2*req_cnt`, and `req_cnt` increments each cycle.
  - Once `req_cnt == WORDS`: `mem_en`=0 and `req_cnt` saturates.
  - Exactly WORDS requests are issued, one per cycle, back-to-back.
- **FILL, receive side:**
  - Each cycle with `memory_data_valid`=1: `write_data_array`=1, `data_word_index = rcv_cnt`, `fill_data = memory_data`, and `rcv_cnt` increments.
  - The memory is in-order, so arrival order equals request order.
- **Last word:** when `memory_data_valid`=1 and `rcv_cnt == WORDS-1`:
  - `write_tag_array`=1 and `fill_done`=1 in the same cycle as the final `write_data_array`.
  - The state returns to IDLE on the next edge.
- **Arithmetic:**
  - `req_cnt` and `rcv_cnt` are log2(WORDS)+1 bits wide.
  - Address addition is 16-bit. The base is block-aligned, so no carry leaves the block.
- **Boundary conditions:**
  - `miss_detected` during FILL, including the `fill_done` cycle, is ignored. A new miss is accepted only once the state is IDLE.
  - `memory_data_valid` after the WORDS-th word, or while in IDLE, has no effect.
  - Requests and returns may overlap in the same cycle. Both counters update independently.
  - Reset mid-fill: immediate return to IDLE, all outputs 0. A partially written block is left without a tag write, so it stays invalid.

## Timing

- Reset values: `fsm_busy`=0, `mem_en`=0, `memory_address`=0, `write_data_array`=0, `write_tag_array`=0, `fill_done`=0, `data_word_index`=0, `fill_data` = `memory_data` (pass-through).
- Cycle T: `miss_detected`=1 in IDLE.
- T+1 to T+WORDS: FILL; `fsm_busy`=1; requests for words 0..WORDS-1 with `mem_en`=1.
- With a memory latency of L cycles, data for request k arrives at T+1+k+L. For the default 4-cycle memory (L=3 after the request edge), the last word arrives at T+WORDS+L.
- `fill_done` is asserted in that last-arrival cycle, and `fsm_busy` falls on the following edge.
- At the defaults, `fsm_busy` is high for 8+L cycles.
- `write_data_array`, `data_word_index`, `fill_data`, `write_tag_array` and `fill_done` are combinational from state, `rcv_cnt` and `memory_data_valid`. They are valid in the same cycle the data arrives.
- `mem_en` and `memory_address` are decoded from registered state, so they are glitch-free from the clock edge.

## Test plan

- **Basic fill:** miss at 16'h1236 with a 4-cycle memory model.
  - Requests 16'h1230, 1232, …, 123E on consecutive cycles with `mem_en`=1.
  - Eight `write_data_array` pulses with indices 0..7 carrying the model data.
  - `write_tag_array` and `fill_done` together with index 7, then `fsm_busy`=0 on the next cycle.
- **Wrap block:** miss at 16'hFFFE.
  - Base 16'hFFF0 and last request 16'hFFFE; no address overflow.
- **Miss while busy:** pulse `miss_detected` with address 16'h4000 mid-fill and again during the `fill_done` cycle.
  - Both are ignored; no 16'h4000 requests.
  - A miss asserted one cycle after `fill_done` starts a new fill at 16'h4000.
- **Stray valids:** assert `memory_data_valid` in IDLE and again after the 8th word.
  - `write_data_array`=0 and the counters are unchanged.
- **Reset mid-fill:** assert `rst` after 3 words have returned.
  - All outputs go to 0 immediately, `write_tag_array` is never asserted, and a subsequent miss performs a full 8-word fill.
- **Gapped returns:** the memory model inserts idle cycles between valids.
  - Indices stay sequential 0..7, and `fsm_busy` holds until the 8th word.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing cache block as pipelined word reads and streams it into the data/tag arrays
module cache_fill_fsm #(
    parameter int WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [15:0]              miss_address,
    input  logic                     memory_data_valid,
    input  logic [15:0]              memory_data,
    output logic                     fsm_busy,
    output logic                     mem_en,
    output logic [15:0]              memory_address,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] data_word_index,
    output logic [15:0]              fill_data,
    output logic                     write_tag_array,
    output logic                     fill_done
);
    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] W_CNT = CW'(WORDS);
    localparam logic [CW-1:0] W_LAST = CW'(WORDS - 1);
    localparam logic [15:0] W_MASK = ~16'(2 * WORDS - 1);
    typedef enum logic {IDLE, FILL} state_t;
    state_t r_state, w_state_nx;
    logic [15:0] r_base, w_base_nx;
    logic [CW-1:0] r_req_cnt, w_req_nx, r_rcv_cnt, w_rcv_nx;
    logic w_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_base    <= 16'h0;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_base    <= w_base_nx;
            r_req_cnt <= w_req_nx;
            r_rcv_cnt <= w_rcv_nx;
        end
    end
    // Request and receive counters advance independently; memory returns in order.
    always_comb begin
        fsm_busy         = r_state == FILL;
        mem_en           = fsm_busy && r_req_cnt < W_CNT;
        memory_address   = mem_en ? r_base + 16'({r_req_cnt, 1'b0}) : 16'h0;
        write_data_array = fsm_busy && memory_data_valid && r_rcv_cnt < W_CNT;
        data_word_index  = r_rcv_cnt[CW-2:0];
        fill_data        = memory_data;
        w_last           = write_data_array && r_rcv_cnt == W_LAST;
        write_tag_array  = w_last;
        fill_done        = w_last;
        w_req_nx         = r_req_cnt + CW'(mem_en);
        w_rcv_nx         = r_rcv_cnt + CW'(write_data_array);
        w_base_nx        = r_base;
        w_state_nx       = w_last ? IDLE : r_state;
        if (r_state == IDLE && miss_detected) begin
            w_state_nx = FILL;
            w_base_nx  = miss_address & W_MASK;
            w_req_nx   = '0;
            w_rcv_nx   = '0;
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench with an in-order 4-cycle memory model
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy, mem_en, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address, fill_data;
    logic [2:0]  data_word_index;

    cache_fill_fsm dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_en(mem_en), .memory_address(memory_address),
        .write_data_array(write_data_array), .data_word_index(data_word_index),
        .fill_data(fill_data), .write_tag_array(write_tag_array), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    logic [15:0] q_a[$];
    int          q_r[$];
    logic [15:0] req_log[$];
    logic [2:0]  idx_log[$];
    logic [15:0] dat_log[$];
    int tag_cnt, tag_bad, done_cnt, done_idx, done_cyc, busy_cnt, busy_last;
    bit gap = 0, stray = 0, miss_on_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        req_log.delete(); idx_log.delete(); dat_log.delete();
        tag_cnt = 0; tag_bad = 0; done_cnt = 0; done_idx = -1;
        done_cyc = -1; busy_cnt = 0; busy_last = -2;
    endtask

    // One cycle: drive inputs, sample outputs away from the edge, advance.
    task automatic tick(input logic m, input logic [15:0] a);
        miss_detected = m;
        miss_address  = a;
        if (q_a.size() > 0 && q_r[0] <= cyc && (!gap || cyc % 2 == 0)) begin
            memory_data_valid = 1'b1;
            memory_data = q_a[0] ^ 16'h5A5A;
            void'(q_a.pop_front());
            void'(q_r.pop_front());
        end else begin
            memory_data_valid = stray;
            memory_data = 16'hDEAD;
        end
        #1;
        if (mem_en) begin
            q_a.push_back(memory_address);
            q_r.push_back(cyc + 3);
            req_log.push_back(memory_address);
        end
        if (write_data_array) begin
            idx_log.push_back(data_word_index);
            dat_log.push_back(fill_data);
        end
        if (write_tag_array) begin
            tag_cnt++;
            if (!write_data_array || !fill_done) tag_bad++;
        end
        if (fill_done) begin
            done_cnt++;
            done_idx = int'(data_word_index);
            done_cyc = cyc;
            if (miss_on_done) begin
                miss_detected = 1'b1;
                miss_address = 16'h4000;
            end
        end
        if (fsm_busy) begin
            busy_cnt++;
            busy_last = cyc;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_fill(input logic [15:0] addr, input bit g, input int mid_k, input int exp_busy);
        logic [15:0] base;
        int n;
        clear_logs();
        gap = g;
        base = addr & 16'hFFF0;
        tick(1'b1, addr);
        n = 0;
        while (fsm_busy && n < 60) begin
            tick(n == mid_k, 16'h4000);
            n++;
        end
        chk("timeout", 32'(n < 60), 32'd1);
        chk("nreq", 32'(req_log.size()), 32'd8);
        chk("nwr", 32'(idx_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < req_log.size(); k++)
            chk($sformatf("req%0d", k), 32'(req_log[k]), 32'(16'(base + 16'(2 * k))));
        for (int k = 0; k < 8 && k < idx_log.size(); k++) begin
            chk($sformatf("idx%0d", k), 32'(idx_log[k]), 32'(k));
            chk($sformatf("dat%0d", k), 32'(dat_log[k]), 32'(16'(base + 16'(2 * k)) ^ 16'h5A5A));
        end
        chk("tag_cnt", 32'(tag_cnt), 32'd1);
        chk("tag_with_wr_done", 32'(tag_bad), 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("done_idx", 32'(done_idx), 32'd7);
        chk("busy_end", 32'(busy_last), 32'(done_cyc));
        if (exp_busy > 0) chk("busy_cnt", 32'(busy_cnt), 32'(exp_busy));
        gap = 0;
        miss_on_done = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0;
        memory_data_valid = 1'b0;
        memory_data = 16'h1234;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(fsm_busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_addr", 32'(memory_address), 32'd0);
        chk("rst_wda", 32'(write_data_array), 32'd0);
        chk("rst_wta", 32'(write_tag_array), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_idx", 32'(data_word_index), 32'd0);
        chk("rst_fill_data", 32'(fill_data), 32'h1234);
        rst = 1'b0;
        @(posedge clk); #1;

        stray = 1;
        tick(1'b0, 16'h0);
        stray = 0;
        chk("stray_idle_wr", 32'(idx_log.size()), 32'd0);
        chk("stray_idle_busy", 32'(fsm_busy), 32'd0);

        run_fill(16'h1236, 0, -1, 11);

        stray = 1;
        tick(1'b0, 16'h0);
        tick(1'b0, 16'h0);
        stray = 0;
        chk("stray_after_wr", 32'(idx_log.size()), 32'd8);
        chk("stray_after_tag", 32'(tag_cnt), 32'd1);
        chk("stray_after_busy", 32'(fsm_busy), 32'd0);

        run_fill(16'hFFFE, 0, -1, 11);

        miss_on_done = 1;
        run_fill(16'h1000, 0, 4, 11);
        run_fill(16'h4000, 0, -1, 11);

        clear_logs();
        tick(1'b1, 16'h2468);
        n = 0;
        while (idx_log.size() < 3 && n < 40) begin
            tick(1'b0, 16'h0);
            n++;
        end
        chk("rst_mid_timeout", 32'(n < 40), 32'd1);
        chk("rst_mid_busy_before", 32'(fsm_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(fsm_busy), 32'd0);
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mid_addr", 32'(memory_address), 32'd0);
        chk("rst_mid_wda", 32'(write_data_array), 32'd0);
        chk("rst_mid_wta", 32'(write_tag_array), 32'd0);
        chk("rst_mid_done", 32'(fill_done), 32'd0);
        chk("rst_mid_idx", 32'(data_word_index), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        q_a.delete();
        q_r.delete();
        cyc++;
        chk("rst_mid_no_tag", 32'(tag_cnt), 32'd0);
        run_fill(16'h2468, 0, -1, 11);

        run_fill(16'h8ACE, 1, -1, 0);
        chk("gap_busy_long", 32'(busy_cnt > 11), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
